// File: rtl/mul_iter_unit_pkg.sv
// Shared types for the iterative RV64M multiplier: op encodings, FSM states,
// and the full-adder cell used by the accumulate adder.
package mul_iter_unit_pkg;

  localparam int MUL_XLEN = 64;

  typedef enum logic [2:0] {
    MUL_OP_MUL    = 3'd0,
    MUL_OP_MULH   = 3'd1,
    MUL_OP_MULHSU = 3'd2,
    MUL_OP_MULHU  = 3'd3,
    MUL_OP_MULW   = 3'd4
  } mul_op_e;

  typedef enum logic [1:0] {
    MUL_ST_IDLE = 2'd0,
    MUL_ST_CALC = 2'd1,
    MUL_ST_DONE = 2'd2
  } mul_st_e;

  // One full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] fa_cell(input logic a, input logic b, input logic ci);
    return {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
  endfunction

  // Reserved encodings 5-7 behave as plain MUL.
  function automatic mul_op_e mul_op_decode(input logic [2:0] raw);
    mul_op_e op;
    case (raw)
      3'd1:    op = MUL_OP_MULH;
      3'd2:    op = MUL_OP_MULHSU;
      3'd3:    op = MUL_OP_MULHU;
      3'd4:    op = MUL_OP_MULW;
      default: op = MUL_OP_MUL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mul_acc_adder.sv
// W-bit ripple-carry adder assembled from full-adder cells.
module mul_acc_adder
  import mul_iter_unit_pkg::*;
#(
  parameter int W = 128
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic       carry;
  logic [1:0] fa_out;

  // Ripple the carry LSB to MSB; a block-local carry keeps the chain acyclic.
  always_comb begin
    carry  = 1'b0;
    fa_out = 2'b00;
    sum_o  = '0;
    for (int i = 0; i < W; i++) begin
      fa_out   = fa_cell(a_i[i], b_i[i], carry);
      sum_o[i] = fa_out[0];
      carry    = fa_out[1];
    end
    cout_o = carry;
  end

endmodule

// File: rtl/mul_iter_unit.sv
// Iterative shift-add RV64M multiplier (MUL/MULH/MULHSU/MULHU/MULW).
// Operands are converted to magnitudes on accept, one add-and-shift step runs
// per cycle, and the sign is applied in a single finishing cycle before DONE.
// Optional build macro MUL_EARLY_OUT_EN: stop iterating as soon as the
// remaining multiplier bits are all zero.
module mul_iter_unit
  import mul_iter_unit_pkg::*;
#(
  parameter int XLEN = MUL_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            mul_valid_i,
  output logic            mul_ready_o,
  input  logic [2:0]      mul_op_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int PW    = 2 * XLEN;
  localparam int HW    = XLEN / 2;
  localparam int CNT_W = $clog2(XLEN);

  mul_st_e          state_q,  state_d;
  mul_op_e          op_q,     op_d;
  logic [PW-1:0]    mcand_q,  mcand_d;
  logic [XLEN-1:0]  mplier_q, mplier_d;
  logic [PW-1:0]    acc_q,    acc_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             neg_q,    neg_d;
  logic             fin_q,    fin_d;   // iterations over, sign/select pending
  logic [XLEN-1:0]  result_q, result_d;

  mul_op_e          op_in;
  logic             a_sgn, b_sgn;
  logic [XLEN-1:0]  a_raw, b_raw, a_mag, b_mag;
  logic [PW-1:0]    add_sum;
  logic             add_cout_unused;
  logic [XLEN-1:0]  mplier_nxt;
  logic [CNT_W-1:0] last_idx;
  logic             last_step;
  logic [PW-1:0]    prod;

  mul_acc_adder #(.W(PW)) u_acc_adder (
    .a_i    (acc_q),
    .b_i    (mcand_q),
    .sum_o  (add_sum),
    .cout_o (add_cout_unused)
  );

  // Decode the incoming request into operand magnitudes and result sign.
  always_comb begin
    op_in = mul_op_decode(mul_op_i);
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    a_raw = src1_i;
    b_raw = src2_i;
    case (op_in)
      MUL_OP_MUL, MUL_OP_MULH: begin
        a_sgn = src1_i[XLEN-1];
        b_sgn = src2_i[XLEN-1];
      end
      MUL_OP_MULHSU: a_sgn = src1_i[XLEN-1];
      MUL_OP_MULW: begin
        a_raw = {{HW{1'b0}}, src1_i[HW-1:0]};
        b_raw = {{HW{1'b0}}, src2_i[HW-1:0]};
      end
      default: ;
    endcase
    // -(2^(XLEN-1)) wraps to itself, which is the correct unsigned magnitude.
    a_mag = a_sgn ? (XLEN)'(-a_raw) : a_raw;
    b_mag = b_sgn ? (XLEN)'(-b_raw) : b_raw;
  end

  // Signed product and per-op result selection used in the finishing cycle.
  always_comb begin
    prod = neg_q ? (PW)'(-acc_q) : acc_q;
    case (op_q)
      MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULHU: result_d = prod[PW-1:XLEN];
      MUL_OP_MULW: result_d = {{(XLEN-HW){prod[HW-1]}}, prod[HW-1:0]};
      default:     result_d = prod[XLEN-1:0];
    endcase
    if (state_q != MUL_ST_CALC || !fin_q || flush_i) result_d = result_q;
  end

  // Next-state and datapath update; flush overrides everything at the end.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    fin_d    = fin_q;

    mplier_nxt = mplier_q >> 1;
    last_idx   = (op_q == MUL_OP_MULW) ? CNT_W'(HW - 1) : CNT_W'(XLEN - 1);
`ifdef MUL_EARLY_OUT_EN
    last_step  = (cnt_q == last_idx) || (mplier_nxt == '0);
`else
    last_step  = (cnt_q == last_idx);
`endif

    case (state_q)
      MUL_ST_IDLE: begin
        if (mul_valid_i) begin
          state_d  = MUL_ST_CALC;
          op_d     = op_in;
          mcand_d  = {{XLEN{1'b0}}, a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = '0;
          neg_d    = a_sgn ^ b_sgn;
          fin_d    = 1'b0;
        end
      end
      MUL_ST_CALC: begin
        if (!fin_q) begin
          if (mplier_q[0]) acc_d = add_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_nxt;
          cnt_d    = cnt_q + CNT_W'(1);
          fin_d    = last_step;
        end else begin
          state_d = MUL_ST_DONE;
          fin_d   = 1'b0;
        end
      end
      MUL_ST_DONE: begin
        if (out_ready_i) state_d = MUL_ST_IDLE;
      end
      default: state_d = MUL_ST_IDLE;
    endcase

    if (flush_i) begin
      state_d = MUL_ST_IDLE;
      fin_d   = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MUL_ST_IDLE;
      op_q     <= MUL_OP_MUL;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      fin_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      fin_q    <= fin_d;
      result_q <= result_d;
    end
  end

  assign mul_ready_o = (state_q == MUL_ST_IDLE);
  assign out_valid_o = (state_q == MUL_ST_DONE);
  assign busy_o      = (state_q != MUL_ST_IDLE);
  assign result_o    = result_q;

endmodule

// File: tb/tb_mul_iter_unit.sv
// Randomized self-checking bench for mul_iter_unit against a 128-bit
// arithmetic reference model; honours MUL_EARLY_OUT_EN for latency.
module tb_mul_iter_unit;

  logic        clk = 1'b0;
  logic        rst, flush_i, mul_valid_i, out_ready_i;
  logic [2:0]  mul_op_i;
  logic [63:0] src1_i, src2_i;
  logic        mul_ready_o, out_valid_o, busy_o;
  logic [63:0] result_o;

  int total = 0;
  int bad   = 0;
  logic [63:0] last_res;

  mul_iter_unit dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .mul_valid_i (mul_valid_i),
    .mul_ready_o (mul_ready_o),
    .mul_op_i    (mul_op_i),
    .src1_i      (src1_i),
    .src2_i      (src2_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Full-width product of the operands as the op interprets them.
  function automatic logic [63:0] ref_mul(input logic [2:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
    logic [127:0] ea, eb, p;
    logic [63:0]  w;
    ea = {{64{a[63]}}, a};
    eb = {{64{b[63]}}, b};
    if (op == 3'd2) eb = {64'd0, b};
    if (op == 3'd3) begin
      ea = {64'd0, a};
      eb = {64'd0, b};
    end
    if (op == 3'd4) begin
      w = {32'd0, a[31:0]} * {32'd0, b[31:0]};
      return {{32{w[31]}}, w[31:0]};
    end
    p = ea * eb;
    if (op == 3'd1 || op == 3'd2 || op == 3'd3) return p[127:64];
    return p[63:0];
  endfunction

  // Cycles from the accept edge to out_valid_o.
  function automatic int ref_lat(input logic [2:0] op, input logic [63:0] b);
    int n;
    n = (op == 3'd4) ? 32 : 64;
`ifdef MUL_EARLY_OUT_EN
    begin
      logic [63:0] mag;
      int len;
      if (op == 3'd4)                        mag = {32'd0, b[31:0]};
      else if (op != 3'd2 && op != 3'd3 && b[63]) mag = -b;
      else                                   mag = b;
      len = 1;
      for (int i = 0; i < 64; i++) if (mag[i]) len = i + 1;
      if (len > n) len = n;
      return len + 1;
    end
`else
    return n + 1;
`endif
  endfunction

  // Present one request and return right after its accept edge.
  task automatic start_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input string tag);
    chk({tag, "_rdy"}, 64'(mul_ready_o), 64'd1);
    mul_valid_i = 1'b1;
    mul_op_i    = op;
    src1_i      = a;
    src2_i      = b;
    @(posedge clk); #1;
    mul_valid_i = 1'b0;
    mul_op_i    = 3'($urandom);
    src1_i      = {$urandom, $urandom};
    src2_i      = {$urandom, $urandom};
  endtask

  task automatic do_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input int hold, input string tag);
    logic [63:0] exp;
    int cyc;
    exp = ref_mul(op, a, b);
    start_op(op, a, b, tag);
    cyc = 0;
    while (!out_valid_o && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'(ref_lat(op, b)));
    chk({tag, "_res"}, result_o, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_res"}, result_o, exp);
      chk({tag, "_hold_vld"}, 64'(out_valid_o), 64'd1);
      chk({tag, "_hold_rdy"}, 64'(mul_ready_o), 64'd0);
    end
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    chk({tag, "_rel_vld"}, 64'(out_valid_o), 64'd0);
    chk({tag, "_rel_rdy"}, 64'(mul_ready_o), 64'd1);
    last_res = exp;
  endtask

  function automatic logic [63:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return {$urandom, $urandom};
      1:       return 64'($urandom_range(0, 15));
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'hFFFF_FFFF_FFFF_FFFF;
      4:       return 64'd0;
      default: return -64'($urandom_range(1, 1000));
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush_i = 1'b0; mul_valid_i = 1'b0; out_ready_i = 1'b0;
    mul_op_i = 3'd0; src1_i = '0; src2_i = '0; last_res = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy",  64'(mul_ready_o), 64'd1);
    chk("rst_vld",  64'(out_valid_o), 64'd0);
    chk("rst_res",  result_o, 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    rst = 1'b0;

    // Directed cases.
    do_op(3'd0, 64'd3, 64'd5, 0, "mul_3x5");
    do_op(3'd1, '1, '1, 0, "mulh_m1");
    do_op(3'd0, '1, '1, 0, "mul_m1");
    do_op(3'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, "mulh_min");
    do_op(3'd2, '1, '1, 0, "mulhsu");
    do_op(3'd3, '1, '1, 0, "mulhu");
    do_op(3'd4, 64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0002, 0, "mulw");
    do_op(3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd11, 0, "op6");
    do_op(3'd3, 64'd0, 64'd1, 20, "bp20");

    // Flush mid-CALC: back to IDLE, result kept, nothing delivered.
    start_op(3'd0, 64'd7, 64'd9, "fl");
    repeat (10) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("fl_vld",  64'(out_valid_o), 64'd0);
    chk("fl_rdy",  64'(mul_ready_o), 64'd1);
    chk("fl_busy", 64'(busy_o), 64'd0);
    chk("fl_res",  result_o, last_res);
    do_op(3'd1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 0, "after_fl");
    repeat (70) @(posedge clk);
    #1;
    chk("fl_quiet", 64'(out_valid_o), 64'd0);

    // Flush beats a same-cycle accept.
    mul_valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1;
    mul_valid_i = 1'b0; flush_i = 1'b0;
    chk("flacc_busy", 64'(busy_o), 64'd0);

    // Flush in DONE beats the out handshake; result stays put.
    start_op(3'd3, 64'd1000, 64'd3000, "fldone");
    for (int i = 0; i < 200 && !out_valid_o; i++) begin
      @(posedge clk); #1;
    end
    chk("fldone_vld0", 64'(out_valid_o), 64'd1);
    flush_i = 1'b1; out_ready_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0; out_ready_i = 1'b0;
    chk("fldone_vld", 64'(out_valid_o), 64'd0);
    chk("fldone_res", result_o, ref_mul(3'd3, 64'd1000, 64'd3000));

    // Reset mid-CALC.
    start_op(3'd0, 64'd123, 64'd456, "rmid");
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rmid_rdy",  64'(mul_ready_o), 64'd1);
    chk("rmid_vld",  64'(out_valid_o), 64'd0);
    chk("rmid_res",  result_o, 64'd0);
    chk("rmid_busy", 64'(busy_o), 64'd0);

    // Random sweep over ops, operand shapes and backpressure.
    for (int n = 0; n < 40; n++) begin
      do_op(3'($urandom_range(0, 7)), pick_val(), pick_val(), $urandom_range(0, 3), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
